bf_norm_ctrl: RTL and testbench



---
 rtl/bf_norm_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_bf_norm_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_norm_ctrl.sv
// Sequencing and normalisation controller for the bilateral-filter
// weighted-sum datapath. Accumulates PASSES numerator/denominator partial
// sums per pixel, divides them with a serial restoring divider and hands
// the normalised pixel to write-back over a valid/ready handshake.
module bf_norm_ctrl #(
    parameter int PART_W = 27,
    parameter int PASSES = 4,
    parameter int ACC_W  = 29,
    parameter int OUT_W  = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [PART_W-1:0]                             part_num,
    input  logic [PART_W-1:0]                             part_den,
    output logic [((PASSES > 1) ? $clog2(PASSES) : 1)-1:0] pass_idx,
    output logic                                          sum_en,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [OUT_W-1:0]                              out_pix,
    output logic [1:0]                                    out_flag
);

    localparam int IDX_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int EXT_W = ACC_W + OUT_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PASSES - 1);
    localparam logic [BIT_W-1:0] TOP_BIT  = BIT_W'(OUT_W - 1);
    localparam logic [OUT_W-1:0] SAT_PIX  = '1;

    localparam logic [1:0] FLAG_NORMAL   = 2'b00;
    localparam logic [1:0] FLAG_SAT      = 2'b01;
    localparam logic [1:0] FLAG_ZERO_DEN = 2'b10;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_CHK,
        ST_DIV,
        ST_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   pass_idx_q, pass_idx_d;
    logic [ACC_W-1:0]   num_q, num_d;
    logic [ACC_W-1:0]   den_q, den_d;
    logic [ACC_W-1:0]   rem_q, rem_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [OUT_W-1:0]   quo_q, quo_d;
    logic [OUT_W-1:0]   pix_q, pix_d;
    logic [1:0]         flag_q, flag_d;

    logic               beat_fire;
    logic [EXT_W-1:0]   num_ext;
    logic [EXT_W-1:0]   den_top;
    logic [EXT_W-1:0]   den_sh;
    logic [EXT_W-1:0]   rem_ext;
    logic [EXT_W-1:0]   rem_diff;
    logic [ACC_W-1:0]   part_num_ext;
    logic [ACC_W-1:0]   part_den_ext;

    // Wide operands so the saturation test and divide steps never truncate
    assign beat_fire    = in_valid && (state_q == ST_ACC);
    assign part_num_ext = ACC_W'(part_num);
    assign part_den_ext = ACC_W'(part_den);
    assign num_ext      = EXT_W'(num_q);
    assign den_top      = {den_q, {OUT_W{1'b0}}};
    assign den_sh       = EXT_W'(den_q) << bit_q;
    assign rem_ext      = EXT_W'(rem_q);
    assign rem_diff     = rem_ext - den_sh;

    // Next-state and datapath updates for accumulate, check, divide, output
    always_comb begin
        state_d    = state_q;
        pass_idx_d = pass_idx_q;
        num_d      = num_q;
        den_d      = den_q;
        rem_d      = rem_q;
        bit_d      = bit_q;
        quo_d      = quo_q;
        pix_d      = pix_q;
        flag_d     = flag_q;

        case (state_q)
            ST_ACC: begin
                if (beat_fire) begin
                    if (pass_idx_q == '0) begin
                        num_d = part_num_ext;
                        den_d = part_den_ext;
                    end else begin
                        num_d = num_q + part_num_ext;
                        den_d = den_q + part_den_ext;
                    end
                    if (pass_idx_q == LAST_IDX) begin
                        pass_idx_d = '0;
                        state_d    = ST_CHK;
                    end else begin
                        pass_idx_d = pass_idx_q + 1'b1;
                    end
                end
            end

            ST_CHK: begin
                if (den_q == '0) begin
                    pix_d   = '0;
                    flag_d  = FLAG_ZERO_DEN;
                    state_d = ST_OUT;
                end else if (num_ext >= den_top) begin
                    pix_d   = SAT_PIX;
                    flag_d  = FLAG_SAT;
                    state_d = ST_OUT;
                end else begin
                    rem_d   = num_q;
                    bit_d   = TOP_BIT;
                    quo_d   = '0;
                    state_d = ST_DIV;
                end
            end

            ST_DIV: begin
                if (rem_ext >= den_sh) begin
                    rem_d        = ACC_W'(rem_diff);
                    quo_d[bit_q] = 1'b1;
                end else begin
                    quo_d[bit_q] = 1'b0;
                end
                if (bit_q == '0) begin
                    pix_d   = quo_d;
                    flag_d  = FLAG_NORMAL;
                    state_d = ST_OUT;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end

            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end

            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State and datapath registers; reset discards any pixel in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACC;
            pass_idx_q <= '0;
            num_q      <= '0;
            den_q      <= '0;
            rem_q      <= '0;
            bit_q      <= '0;
            quo_q      <= '0;
            pix_q      <= '0;
            flag_q     <= '0;
        end else begin
            state_q    <= state_d;
            pass_idx_q <= pass_idx_d;
            num_q      <= num_d;
            den_q      <= den_d;
            rem_q      <= rem_d;
            bit_q      <= bit_d;
            quo_q      <= quo_d;
            pix_q      <= pix_d;
            flag_q     <= flag_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign sum_en    = in_ready;
    assign out_valid = (state_q == ST_OUT);
    assign out_pix   = pix_q;
    assign out_flag  = flag_q;
    assign pass_idx  = pass_idx_q;

endmodule

// File: tb/tb_bf_norm_ctrl.sv
// Directed testbench for bf_norm_ctrl: accumulation, divide results,
// saturation and zero-denominator paths, latency, backpressure and reset.
module tb_bf_norm_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] part_num;
    logic [26:0] part_den;
    logic [1:0]  pass_idx;
    logic        sum_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pix;
    logic [1:0]  out_flag;

    int checks;
    int errors;

    bf_norm_ctrl #(
        .PART_W(27),
        .PASSES(4),
        .ACC_W (29),
        .OUT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .part_num (part_num),
        .part_den (part_den),
        .pass_idx (pass_idx),
        .sum_en   (sum_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pix  (out_pix),
        .out_flag (out_flag)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the bench can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Present four back-to-back beats; the last is accepted at the returned edge
    task automatic send_beats(input logic [26:0] n0, n1, n2, n3,
                              input logic [26:0] d0, d1, d2, d3);
        @(negedge clk); in_valid = 1'b1; part_num = n0; part_den = d0;
        @(negedge clk); part_num = n1; part_den = d1;
        @(negedge clk); part_num = n2; part_den = d2;
        @(negedge clk); part_num = n3; part_den = d3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        part_num = 27'h1234567;
        part_den = 27'h0ABCDEF;
    endtask

    // Count cycles after the last accepted beat until out_valid; -1 on timeout
    task automatic wait_out(input int max_cycles, output int lat);
        bit seen;
        lat  = -1;
        seen = 1'b0;
        for (int c = 1; c <= max_cycles && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat  = c;
                seen = 1'b1;
            end
        end
    endtask

    // Complete the output handshake from a negedge where out_valid is high
    task automatic do_handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        part_num  = '0;
        part_den  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (sum_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_sum_en: got %b expected 1", sum_en);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_pix !== 8'd0 || out_flag !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got pix %0d flag %b expected pix 0 flag 00", out_pix, out_flag);
        end
        checks++;
        if (pass_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_pass_idx: got %0d expected 0", pass_idx);
        end
    endtask

    task automatic test_normal();
        int lat;
        send_beats(27'd100, 27'd200, 27'd300, 27'd400, 27'd5, 27'd5, 27'd5, 27'd5);
        checks++;
        if (in_ready !== 1'b0 || pass_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL normal_after_beats: got in_ready %b pass_idx %0d expected 0 and 0", in_ready, pass_idx);
        end
        wait_out(40, lat);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("[TB] FAIL normal_latency: got %0d expected 10", lat);
        end
        checks++;
        if (out_pix !== 8'd50 || out_flag !== 2'b00) begin
            errors++;
            $display("[TB] FAIL normal_result: got pix %0d flag %b expected pix 50 flag 00", out_pix, out_flag);
        end
        do_handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL normal_release: got out_valid %b in_ready %b expected 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_zero_den();
        int lat;
        send_beats(27'd7, 27'd8, 27'd9, 27'd10, 27'd0, 27'd0, 27'd0, 27'd0);
        wait_out(40, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL zero_den_latency: got %0d expected 2", lat);
        end
        checks++;
        if (out_pix !== 8'd0 || out_flag !== 2'b10) begin
            errors++;
            $display("[TB] FAIL zero_den_result: got pix %0d flag %b expected pix 0 flag 10", out_pix, out_flag);
        end
        do_handshake();
    endtask

    task automatic test_saturate();
        int lat;
        send_beats(27'd2500, 27'd2500, 27'd2500, 27'd2500, 27'd10, 27'd0, 27'd0, 27'd0);
        wait_out(40, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL sat_latency: got %0d expected 2", lat);
        end
        checks++;
        if (out_pix !== 8'd255 || out_flag !== 2'b01) begin
            errors++;
            $display("[TB] FAIL sat_result: got pix %0d flag %b expected pix 255 flag 01", out_pix, out_flag);
        end
        do_handshake();
    endtask

    task automatic test_boundary();
        int lat;
        // 2559 / 10 is just below the saturation threshold of 10 << 8
        send_beats(27'd2559, 27'd0, 27'd0, 27'd0, 27'd10, 27'd0, 27'd0, 27'd0);
        wait_out(40, lat);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("[TB] FAIL bound_below_latency: got %0d expected 10", lat);
        end
        checks++;
        if (out_pix !== 8'd255 || out_flag !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bound_below_result: got pix %0d flag %b expected pix 255 flag 00", out_pix, out_flag);
        end
        do_handshake();
        // 2560 / 10 hits the threshold exactly and saturates
        send_beats(27'd2560, 27'd0, 27'd0, 27'd0, 27'd10, 27'd0, 27'd0, 27'd0);
        wait_out(40, lat);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("[TB] FAIL bound_at_latency: got %0d expected 2", lat);
        end
        checks++;
        if (out_pix !== 8'd255 || out_flag !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bound_at_result: got pix %0d flag %b expected pix 255 flag 01", out_pix, out_flag);
        end
        do_handshake();
    endtask

    task automatic test_backpressure();
        logic [26:0] nb[4];
        logic [26:0] db[4];
        int          lat;
        int          gap;
        nb[0] = 27'd50; nb[1] = 27'd60; nb[2] = 27'd70; nb[3] = 27'd80;
        db[0] = 27'd3;  db[1] = 27'd3;  db[2] = 27'd3;  db[3] = 27'd3;
        // 260 / 12 = 21 with idle gaps carrying junk data between beats
        for (int i = 0; i < 4; i++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                part_num = 27'h5A5A5;
                part_den = 27'h777;
            end
            @(negedge clk);
            checks++;
            if (pass_idx !== 2'(i)) begin
                errors++;
                $display("[TB] FAIL bp_pass_idx: got %0d expected %0d", pass_idx, i);
            end
            in_valid = 1'b1;
            part_num = nb[i];
            part_den = db[i];
        end
        @(posedge clk); #1;
        // Next pixel's first beat waits at the input the whole time
        in_valid = 1'b1;
        part_num = 27'd1000;
        part_den = 27'd100;
        wait_out(40, lat);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("[TB] FAIL bp_latency: got %0d expected 10", lat);
        end
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_pix !== 8'd21 || out_flag !== 2'b00 || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold: got valid %b pix %0d flag %b in_ready %b expected 1 21 00 0",
                         out_valid, out_pix, out_flag, in_ready);
            end
        end
        @(negedge clk);
        do_handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || pass_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL bp_release: got valid %b in_ready %b pass_idx %0d expected 0 1 0",
                     out_valid, in_ready, pass_idx);
        end
        @(posedge clk); #1;
        checks++;
        if (pass_idx !== 2'd1) begin
            errors++;
            $display("[TB] FAIL bp_first_beat: got pass_idx %0d expected 1", pass_idx);
        end
        part_num = 27'd0;
        part_den = 27'd0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(40, lat);
        checks++;
        if (lat !== 10 || out_pix !== 8'd10 || out_flag !== 2'b00) begin
            errors++;
            $display("[TB] FAIL bp_next_pixel: got lat %0d pix %0d flag %b expected 10 10 00", lat, out_pix, out_flag);
        end
        do_handshake();
    endtask

    task automatic test_max_inputs();
        int lat;
        send_beats(27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF,
                   27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF, 27'h7FFFFFF);
        wait_out(40, lat);
        checks++;
        if (lat !== 10 || out_pix !== 8'd1 || out_flag !== 2'b00) begin
            errors++;
            $display("[TB] FAIL max_inputs: got lat %0d pix %0d flag %b expected 10 1 00", lat, out_pix, out_flag);
        end
        do_handshake();
    endtask

    task automatic test_reset_mid_div();
        int lat;
        send_beats(27'd1000, 27'd0, 27'd0, 27'd0, 27'd20, 27'd0, 27'd0, 27'd0);
        // Cycle T+1 is the check, T+2..T+9 divide; T+5 is the 4th divide cycle
        repeat (5) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL middiv_busy: got in_ready %b out_valid %b expected 0 0", in_ready, out_valid);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || pass_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL middiv_reset: got valid %b in_ready %b pass_idx %0d expected 0 1 0",
                     out_valid, in_ready, pass_idx);
        end
        send_beats(27'd300, 27'd300, 27'd300, 27'd0, 27'd10, 27'd10, 27'd10, 27'd0);
        wait_out(40, lat);
        checks++;
        if (lat !== 10 || out_pix !== 8'd30 || out_flag !== 2'b00) begin
            errors++;
            $display("[TB] FAIL middiv_clean: got lat %0d pix %0d flag %b expected 10 30 00", lat, out_pix, out_flag);
        end
        do_handshake();
    endtask

    // Scenario sequence
    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_normal();
        test_zero_den();
        test_saturate();
        test_boundary();
        test_backpressure();
        test_max_inputs();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
